dbus_bridge: RTL
================

Name: dbus_bridge

Overview:
- Data-side responder for the pipelined CPU's memory port. It takes the CPU's MEM-stage address, write data and write enable, and returns read data in the same cycle.
- Decodes each address to one of three targets: external data RAM, memory-mapped peripherals (LEDs, switches, buttons, 7-segment display, cycle timer), or unmapped space.
- Sits between the CPU core and the board-level RAM/IO in the SoC top.

Parameters:
- RAM_AW, 16, word-address width presented to the data RAM (RAM covers byte addresses 0x0000_0000..(4<<RAM_AW)-1).
- SCAN_DIV, 20000, clk cycles spent on each 7-segment digit before advancing to the next.
- SYNC_STAGES, 2, number of flip-flop stages in each switch/button input synchronizer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- adr_i  in  32  byte address from the CPU (ALU result, MEM stage)
- wdata_i  in  32  store data from the CPU
- we_i  in  1  store enable from the CPU
- rdata_o  out  32  load data to the CPU; combinational from adr_i
- ram_adr_o  out  RAM_AW  word address, equal to adr_i[RAM_AW+1:2]
- ram_we_o  out  1  RAM write strobe
- ram_wdata_o  out  32  RAM write data, equal to wdata_i
- ram_rdata_i  in  32  RAM asynchronous read data
- sw_i  in  24  raw board switches (asynchronous)
- btn_i  in  5  raw board buttons (asynchronous)
- led_o  out  24  LED register
- seg_an_o  out  8  7-segment digit enables, active-low
- seg_cx_o  out  8  7-segment segments {dp,g..a}, active-low

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named rst_n.
- Reset values:
  - led_o = 0; display register = 0; timer = 0; scan counter = 0; digit index = 0.
  - Synchronizer flops = 0.
  - seg_an_o = 8'hFE; seg_cx_o = 8'hC0 (shows "0"; dp off).
- Address map (full 32-bit compare for peripherals):
  - 0xFFFF_F000: display register, R/W.
  - 0xFFFF_F020: timer, R/W.
  - 0xFFFF_F060: LEDs, R/W; only bits [23:0] are stored and read.
  - 0xFFFF_F070: switches, read-only; reads {8'h0, synchronized sw}.
  - 0xFFFF_F078: buttons, read-only; reads {27'h0, synchronized btn}.
  - adr_i[31:RAM_AW+2] == 0: RAM.
  - Anything else: unmapped.
- Reads: rdata_o is purely combinational, with zero-cycle latency. Unmapped reads return 32'h0. adr_i[1:0] is ignored everywhere (word accesses only).
- Writes:
  - A peripheral register updates at the posedge where we_i = 1 and its address decodes.
  - ram_we_o = we_i AND RAM decode; it is combinational, and the RAM commits the write at that same posedge.
  - Writes to read-only or unmapped addresses are dropped with no side effects.
- Timer:
  - Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - A write loads wdata_i; on the same edge, the write wins and there is no increment.
  - A read returns the pre-edge value.
- Synchronizers: sw and btn pass through SYNC_STAGES flops. A change on the pins is first visible in rdata_o SYNC_STAGES rising edges later.
- 7-segment scanner:
  - The scan counter counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it returns to 0, and the digit index advances 0→7, then wraps to 0.
  - seg_an_o = ~(1 << digit index).
  - seg_cx_o = hex decode of display[4*idx+3 : 4*idx], with dp = 1 (off).
  - seg_an_o and seg_cx_o are registered: both change on the same edge as the index, so there is never a glitch between digits.
  - A display write mid-scan is reflected on the current digit's cathodes at the next edge.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset mid-operation: all registers clear immediately, asynchronously. ram_we_o still follows we_i combinationally, and the CPU is held in reset by the same rst_n.

Decomposition:
- Shared package dbus_pkg holds:
  - address constants ADR_DISP, ADR_TIMER, ADR_LED, ADR_SW, ADR_BTN;
  - the 16-entry hex-to-segment constant table / decode function.
- One sub-module, seg7_scan, contains: scan counter, digit index, and the registered anode/cathode outputs. Its inputs are clk, rst_n and the 32-bit display value.
- Decode, peripheral registers, timer and synchronizers stay in dbus_bridge.

Test Plan:
- RAM path: adr_i=0x0000_0104, we_i=1, wdata_i=0xDEADBEEF → ram_we_o=1 and ram_adr_o=0x41 that cycle. A later read at 0x104 with ram_rdata_i=0xDEADBEEF → rdata_o=0xDEADBEEF with no delay.
- LED and unmapped:
  - Write 0xFFFF_FFFF to 0xFFFF_F060 → led_o=0xFFFFFF and readback = 0x00FFFFFF.
  - Write to 0x8000_0000 → ram_we_o=0, no register changes, read returns 0.
- Switch sync: sw_i steps 0→0x00A5A5 → rdata_o at 0xFFFF_F070 still 0 after 1 edge, 0x00A5A5 after the 2nd edge.
- Timer:
  - Write 0xFFFF_FFFE → reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0 on successive cycles.
  - Write 5 on the same edge as an increment → next read = 5.
- Display scan (SCAN_DIV=4): write 0x1234_5678 to 0xFFFF_F000 → digit 0 (seg_an_o=FE) shows seg_cx_o=0x80 ("8"). After 4 cycles: seg_an_o=FD, seg_cx_o=0xF8 ("7"). After 32 cycles the index wraps back to FE.
- Reset mid-scan: assert rst_n=0 asynchronously while digit 5 is active → seg_an_o=FE, led_o=0 and timer=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/dbus_pkg.sv
// dbus_pkg: address map and 7-segment decode shared by the data-bus bridge
package dbus_pkg;
  localparam logic [31:0] ADR_DISP  = 32'hFFFF_F000;
  localparam logic [31:0] ADR_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] ADR_LED   = 32'hFFFF_F060;
  localparam logic [31:0] ADR_SW    = 32'hFFFF_F070;
  localparam logic [31:0] ADR_BTN   = 32'hFFFF_F078;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] seg_hex(input logic [3:0] d);
    return SEG_LUT[d];
  endfunction
endpackage

// File: rtl/dbus_bridge_seg7_scan.sv
// seg7_scan: time-multiplexes eight hex digits onto one active-low 7-segment bus
module seg7_scan
  import dbus_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cx
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [2:0] idx, nidx;
  logic wrap;
  assign wrap = cnt == CW'(SCAN_DIV - 1);
  assign nidx = wrap ? idx + 3'd1 : idx;
  // anodes and cathodes are both built from the next index so they switch together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      seg_an <= 8'hFE;
      seg_cx <= 8'hC0;
    end else begin
      cnt    <= wrap ? '0 : cnt + CW'(1);
      idx    <= nidx;
      seg_an <= ~(8'd1 << nidx);
      seg_cx <= {1'b1, seg_hex(display[{nidx, 2'b00} +: 4])};
    end
endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge: decodes CPU data accesses onto RAM and memory-mapped board peripherals
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int RAM_AW      = 16,
  parameter int SCAN_DIV    = 20000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       adr_i,
  input  logic [31:0]       wdata_i,
  input  logic              we_i,
  output logic [31:0]       rdata_o,
  output logic [RAM_AW-1:0] ram_adr_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  input  logic [23:0]       sw_i,
  input  logic [4:0]        btn_i,
  output logic [23:0]       led_o,
  output logic [7:0]        seg_an_o,
  output logic [7:0]        seg_cx_o
);
  logic [31:0] disp, timer, adr_w;
  logic [23:0] led;
  logic [SYNC_STAGES-1:0][23:0] sw_q;
  logic [SYNC_STAGES-1:0][4:0] btn_q;
  logic hit_disp, hit_timer, hit_led, hit_sw, hit_btn, hit_ram;
  logic unused_lsb;
  assign unused_lsb  = ^adr_i[1:0];
  assign adr_w       = {adr_i[31:2], 2'b00};
  assign hit_disp    = adr_w == ADR_DISP;
  assign hit_timer   = adr_w == ADR_TIMER;
  assign hit_led     = adr_w == ADR_LED;
  assign hit_sw      = adr_w == ADR_SW;
  assign hit_btn     = adr_w == ADR_BTN;
  assign hit_ram     = adr_i[31:RAM_AW+2] == '0;
  assign ram_adr_o   = adr_i[RAM_AW+1:2];
  assign ram_we_o    = we_i & hit_ram;
  assign ram_wdata_o = wdata_i;
  assign led_o       = led;
  // zero-latency read mux; unmapped space reads as zero
  always_comb
    rdata_o = hit_disp  ? disp :
              hit_timer ? timer :
              hit_led   ? {8'h0, led} :
              hit_sw    ? {8'h0, sw_q[SYNC_STAGES-1]} :
              hit_btn   ? {27'h0, btn_q[SYNC_STAGES-1]} :
              hit_ram   ? ram_rdata_i : 32'h0;
  // writable peripheral registers; a timer write overrides that cycle's increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp  <= '0;
      timer <= '0;
      led   <= '0;
    end else begin
      if (we_i && hit_disp) disp <= wdata_i;
      if (we_i && hit_led) led <= wdata_i[23:0];
      timer <= (we_i && hit_timer) ? wdata_i : timer + 32'd1;
    end
  // multi-flop synchronizers for the asynchronous switch and button pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sw_q  <= '0;
      btn_q <= '0;
    end else begin
      sw_q[0]  <= sw_i;
      btn_q[0] <= btn_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_q[i]  <= sw_q[i-1];
        btn_q[i] <= btn_q[i-1];
      end
    end
  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .display(disp),
    .seg_an (seg_an_o),
    .seg_cx (seg_cx_o)
  );
endmodule
